// File: rtl/lsu_pkg.sv
// Shared LSU definitions: RV32I funct3 width codes, FSM state, access size,
// legality/size helpers and the default memory timeout.
package lsu_pkg;

   localparam int LSU_TIMEOUT_DEF = 16;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} lsu_state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

   function automatic lsu_size_e f3_size(input logic [1:0] f3_lo);
      case (f3_lo)
         2'd0:    return SZ_B;
         2'd1:    return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) return f3 inside {F3_B, F3_H, F3_W};
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and lane replication, and load
// extraction with sign/zero extension from the addressed lanes.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] ld_data
);

   lsu_size_e   size;
   logic [31:0] sh;
   logic        sext;

   assign size = f3_size(funct3[1:0]);
   assign sh   = rdata >> {addr_lo, 3'b000};
   assign sext = ~funct3[2];

   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      ld_data   = sh;
      case (size)
         SZ_B: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            ld_data   = {{24{sh[7] & sext}}, sh[7:0]};
         end
         SZ_H: begin
            be        = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
            ld_data   = {{16{sh[15] & sext}}, sh[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE/BUSY/DONE handshake to data memory with timeout.
// Build option LSU_MISALIGN_TRAP_EN: fault misaligned half/word instead of aligning down.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   lsu_state_e  state_q, state_d;
   logic        we_q, fault_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [CW-1:0] cnt_q, cnt_inc;
   logic        tmo, busy;

   lsu_size_e   req_size;
   logic        req_ok;
   logic [31:0] req_addr_al;

   logic [3:0]  be;
   logic [31:0] wdata_rep, ld_data;

   assign req_size = f3_size(req_funct3[1:0]);
   assign cnt_inc  = cnt_q + 1'b1;
   assign tmo      = (cnt_inc == CW'(TIMEOUT_CYC));
   assign busy     = (state_q == ST_BUSY);

   // Misaligned half/word is either trapped or silently aligned down to its size.
`ifdef LSU_MISALIGN_TRAP_EN
   logic req_mis;
   assign req_mis = ((req_size == SZ_H) && req_addr[0]) ||
                    ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
   assign req_ok  = f3_legal(req_we, req_funct3) && !req_mis;
`else
   assign req_ok  = f3_legal(req_we, req_funct3);
`endif

   always_comb begin
      req_addr_al = req_addr;
      case (req_size)
         SZ_H:    req_addr_al = {req_addr[31:1], 1'b0};
         SZ_W:    req_addr_al = {req_addr[31:2], 2'b00};
         default: ;
      endcase
   end

   lsu_align u_align (
      .addr_lo   (addr_q[1:0]),
      .funct3    (f3_q),
      .wdata     (wdata_q),
      .rdata     (mem_rdata),
      .be        (be),
      .wdata_rep (wdata_rep),
      .ld_data   (ld_data)
   );

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               stall   = 1'b1;
               state_d = req_ok ? ST_BUSY : ST_DONE;
            end
         end
         ST_BUSY: begin
            stall = 1'b1;
            if (mem_ack || tmo) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr_al;
                  wdata_q <= req_wdata;
                  rdata_q <= '0;
                  fault_q <= !req_ok;
                  cnt_q   <= '0;
               end
            end
            ST_BUSY: begin
               cnt_q <= cnt_inc;
               // An ack in the timeout cycle still completes cleanly.
               if (mem_ack) begin
                  fault_q <= 1'b0;
                  rdata_q <= we_q ? 32'd0 : ld_data;
               end else if (tmo) begin
                  fault_q <= 1'b1;
                  rdata_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = (state_q == ST_DONE);
   assign fault     = rsp_valid & fault_q;
   assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
   assign mem_req   = busy;
   assign mem_we    = busy & we_q;
   assign mem_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
   assign mem_be    = busy ? be : 4'd0;
   assign mem_wdata = busy ? wdata_rep : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions against a transaction-level reference model.
module tb_load_store_unit;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        stall, rsp_valid, fault, mem_req, mem_we;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;

   int checks = 0;
   int failures = 0;

   load_store_unit #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fault(fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Transaction-level expectation from the access rules.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                        output logic emem, output logic efault, output logic [3:0] ebe,
                        output logic [31:0] ewd, output logic [31:0] eaddr,
                        output logic [31:0] erd, output int elat);
      int sz, off;
      logic legal, acked;
      logic [31:0] szu, eff, v, msk;
      sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      szu   = 32'(sz);
      legal = we ? (f3 < 3'd3) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      emem  = legal;
`ifdef LSU_MISALIGN_TRAP_EN
      if ((addr % szu) != 32'd0) emem = 1'b0;
`endif
      eff   = addr - (addr % szu);
      off   = int'(eff % 32'd4);
      eaddr = eff - 32'(off);
      ebe   = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
      acked  = emem && ack_at >= 1 && ack_at <= TO;
      elat   = !emem ? 1 : (acked ? ack_at + 1 : TO + 1);
      efault = !acked;
      erd    = 32'd0;
      if (acked && !we) begin
         v = rd >> (8 * off);
         if (sz < 4) begin
            msk = (32'd1 << (8 * sz)) - 32'd1;
            v   = v & msk;
            if (!f3[2] && v[8*sz-1]) v = v | ~msk;
         end
         erd = v;
      end
   endtask

   // Issue one request from IDLE, ack it in BUSY cycle ack_at (0 = never),
   // check everything against the model and return what was observed.
   task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                        output logic [3:0] o_be, output logic [31:0] o_addr,
                        output logic [31:0] o_wd, output logic [31:0] o_rd,
                        output logic o_fault, output int o_nreq);
      logic emem, efault;
      logic [3:0] ebe;
      logic [31:0] ewd, eaddr, erd;
      int elat, lat;
      model(we, f3, addr, wd, rd, ack_at, emem, efault, ebe, ewd, eaddr, erd, elat);
      o_be = 'x; o_addr = 'x; o_wd = 'x; o_rd = 'x; o_fault = 1'bx; o_nreq = 0;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      #1 chk("stall_req", 32'(stall), 32'd1);
      lat = 0;
      for (int c = 1; c <= TO + 4 && lat == 0; c++) begin
         @(posedge clk); #1;
         mem_ack   = (c == ack_at);
         mem_rdata = (c == ack_at) ? rd : $urandom;
         #1;
         if (rsp_valid) begin
            lat = c;
            o_rd = rsp_rdata; o_fault = fault;
            chk("rsp_fault", 32'(fault), 32'(efault));
            chk("rsp_rdata", rsp_rdata, erd);
            chk("stall_done", 32'(stall), 32'd0);
            chk("mem_req_done", 32'(mem_req), 32'd0);
         end else if (mem_req) begin
            if (o_nreq == 0) begin o_be = mem_be; o_addr = mem_addr; o_wd = mem_wdata; end
            o_nreq++;
            chk("mem_be", 32'(mem_be), 32'(ebe));
            chk("mem_addr", mem_addr, eaddr);
            chk("mem_we", 32'(mem_we), 32'(we));
            if (we) chk("mem_wdata", mem_wdata, ewd);
            chk("stall_busy", 32'(stall), 32'd1);
         end
      end
      chk("latency", 32'(lat), 32'(elat));
      chk("mem_req_cycles", 32'(o_nreq), emem ? 32'(elat - 1) : 32'd0);
      // req_valid is still high during DONE; it must not start a new access.
      @(posedge clk); #1;
      mem_ack = 1'b0; req_valid = 1'b0;
      #1;
      chk("idle_mem_req", 32'(mem_req), 32'd0);
      chk("idle_rsp", 32'(rsp_valid), 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
   endtask

   initial begin
      logic [3:0] o_be;
      logic [31:0] o_addr, o_wd, o_rd;
      logic o_fault;
      int o_nreq, ack_at, r;

      @(posedge clk); #1;
      chk("rst_ctrl", {28'd0, stall, rsp_valid, fault, mem_req}, 32'd0);
      chk("rst_we_be", {27'd0, mem_we, mem_be}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;

      do_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 1, o_be, o_addr, o_wd, o_rd, o_fault, o_nreq);
      chk("sw_be", 32'(o_be), 32'hF);
      chk("sw_addr", o_addr, 32'h100);
      chk("sw_wdata", o_wd, 32'hDEADBEEF);
      chk("sw_fault", 32'(o_fault), 32'd0);
      chk("sw_rdata", o_rd, 32'd0);

      do_op(1'b0, 3'd0, 32'h103, 32'h0, 32'h80112233, 1, o_be, o_addr, o_wd, o_rd, o_fault, o_nreq);
      chk("lb_rdata", o_rd, 32'hFFFFFF80);
      chk("lb_be", 32'(o_be), 32'h8);
      do_op(1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 2, o_be, o_addr, o_wd, o_rd, o_fault, o_nreq);
      chk("lbu_rdata", o_rd, 32'h00000080);

      do_op(1'b1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0, 1, o_be, o_addr, o_wd, o_rd, o_fault, o_nreq);
      chk("sh_be", 32'(o_be), 32'hC);
      chk("sh_wdata", o_wd, 32'hABCDABCD);
      chk("sh_addr", o_addr, 32'h100);

      do_op(1'b0, 3'd2, 32'h200, 32'h0, 32'h12345678, 0, o_be, o_addr, o_wd, o_rd, o_fault, o_nreq);
      chk("tmo_fault", 32'(o_fault), 32'd1);
      chk("tmo_rdata", o_rd, 32'd0);
      chk("tmo_reqs", 32'(o_nreq), 32'd16);
      do_op(1'b0, 3'd2, 32'h200, 32'h0, 32'h12345678, TO, o_be, o_addr, o_wd, o_rd, o_fault, o_nreq);
      chk("ack16_fault", 32'(o_fault), 32'd0);
      chk("ack16_rdata", o_rd, 32'h12345678);

      do_op(1'b0, 3'd2, 32'h102, 32'h0, 32'hCAFEF00D, 1, o_be, o_addr, o_wd, o_rd, o_fault, o_nreq);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_fault", 32'(o_fault), 32'd1);
      chk("mis_reqs", 32'(o_nreq), 32'd0);
`else
      chk("mis_addr", o_addr, 32'h100);
      chk("mis_fault", 32'(o_fault), 32'd0);
      chk("mis_rdata", o_rd, 32'hCAFEF00D);
`endif

      do_op(1'b0, 3'd3, 32'h300, 32'h0, 32'h0, 1, o_be, o_addr, o_wd, o_rd, o_fault, o_nreq);
      chk("ill_ld_fault", 32'(o_fault), 32'd1);
      chk("ill_ld_reqs", 32'(o_nreq), 32'd0);
      do_op(1'b1, 3'd4, 32'h300, 32'h5, 32'h0, 1, o_be, o_addr, o_wd, o_rd, o_fault, o_nreq);
      chk("ill_st_fault", 32'(o_fault), 32'd1);

      // Stray acks while idle are ignored.
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      #1;
      chk("stray_ack_rsp", 32'(rsp_valid), 32'd0);
      chk("stray_ack_req", 32'(mem_req), 32'd0);

      // Reset in the second BUSY cycle, ack arriving one cycle later.
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h400;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rstbusy_req", 32'(mem_req), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11111111;
      #1;
      chk("rstbusy_req_drop", 32'(mem_req), 32'd0);
      chk("rstbusy_rsp0", 32'(rsp_valid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         #1;
         chk("rstbusy_rsp", 32'(rsp_valid), 32'd0);
         chk("rstbusy_req", 32'(mem_req), 32'd0);
      end

      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         ack_at = (r < 6) ? $urandom_range(1, 4) : (r < 8) ? $urandom_range(TO - 2, TO + 2) : 0;
         do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
               ack_at, o_be, o_addr, o_wd, o_rd, o_fault, o_nreq);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16: maximum cycles in BUSY awaiting mem_ack before a fault.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core presents a load/store this cycle
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU; SB/SH/SW)
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- stall  out  1  core must hold PC and request stable
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  32  extended load data to write-back mux
- fault  out  1  completion is an error, qualifies rsp_valid
- mem_req  out  1  data-memory request, held until mem_ack
- mem_we  out  1  data-memory write enable
- mem_addr  out  32  word-aligned address (bits[1:0]=0)
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory completes request this cycle
- mem_rdata  in  32  read word, valid with mem_ack

Function
REQ-003 SHALL implement FSM IDLE, BUSY, DONE.
REQ-004 IDLE: req_valid=1 with legal aligned op -> register request, BUSY; stall=1 combinationally in that cycle.
REQ-005 BUSY: mem_req=1 with mem_we/mem_addr/mem_wdata/mem_be constant; stall=1; on mem_ack -> DONE.
REQ-006 DONE: rsp_valid=1, stall=0 for exactly one cycle, then IDLE; req_valid ignored in DONE.
REQ-007 Minimum latency: request in cycle N, mem_ack in cycle N+1 -> rsp_valid in N+2.
REQ-008 mem_be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
REQ-009 mem_wdata: byte replicated ×4, half replicated ×2, word unchanged.
REQ-010 Loads: mem_rdata shifted right by 8*addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU); captured on mem_ack.
REQ-011 Stores: rsp_rdata=0 at completion.
REQ-012 Cycle counter clears on BUSY entry, increments each BUSY cycle; reaching TIMEOUT_CYC without ack -> DONE with fault=1, rsp_rdata=0, mem_req deasserted.
REQ-013 mem_ack in the same cycle the counter reaches TIMEOUT_CYC: ack wins, no fault.
REQ-014 Illegal funct3 (load 3/6/7, store ≥3) -> no memory request; DONE next cycle with fault=1.
REQ-015 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-016 rst=1 at a clock edge -> state IDLE, counter 0, all outputs 0, next cycle.
REQ-017 rst asserted in BUSY drops mem_req next cycle; a later ack produces no response.

Configuration
REQ-018 Macro LSU_MISALIGN_TRAP_EN defined: misaligned half (addr[0]=1) or word (addr[1:0]≠0) -> no memory request, DONE next cycle, fault=1.
REQ-019 Undefined: misaligned address aligned down to access size and executed normally, fault=0.

Structure
REQ-020 Package lsu_pkg SHALL hold funct3 constants, state enum, access-size typedef, and the default timeout.
REQ-021 Combinational sub-module lsu_align SHALL compute mem_be, mem_wdata, and load extraction; FSM and counter stay in load_store_unit.

Verification
REQ-022 SW addr 0x100, wdata 0xDEADBEEF, ack after 1 cycle -> mem_be=1111, mem_addr=0x100, rsp_valid in N+2, fault=0.
REQ-023 LB addr 0x103, mem_rdata 0x80112233 -> rsp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-024 SH addr 0x102, wdata 0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x100.
REQ-025 LW no ack for 16 cycles -> fault=1, rsp_rdata=0, mem_req low after; ack on exactly the 16th cycle -> no fault.
REQ-026 LW addr 0x102: with LSU_MISALIGN_TRAP_EN, fault=1, mem_req never high; without, mem_addr=0x100, fault=0.
REQ-027 rst in 2nd BUSY cycle, ack 1 cycle later -> mem_req=0, rsp_valid stays 0.
